// File: rtl/wb_burst_master_if.sv
// Bundle of the command, write-data, read-data and Wishbone signals of wb_burst_master.
// The master modport is the initiator's view; the slave modport is the traffic source / slave side.
interface wb_burst_master_if #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int bl = 5
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_we;
  logic [aw-1:0]   cmd_addr;
  logic [bl-1:0]   cmd_len;
  logic [dw/8-1:0] cmd_sel;
  logic            wdat_valid;
  logic            wdat_ready;
  logic [dw-1:0]   wdat;
  logic            rdat_valid;
  logic [dw-1:0]   rdat;
  logic            rdat_last;
  logic            done;
  logic            err;
  logic            busy;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [aw-1:0]   wb_addr_o;
  logic [dw-1:0]   wb_dat_o;
  logic [dw/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [dw-1:0]   wb_dat_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_sel, wdat_valid, wdat,
           wb_ack_i, wb_dat_i,
    output cmd_ready, wdat_ready, rdat_valid, rdat, rdat_last, done, err, busy,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_sel, wdat_valid, wdat,
           wb_ack_i, wb_dat_i,
    input  cmd_ready, wdat_ready, rdat_valid, rdat, rdat_last, done, err, busy,
           wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
  );
endinterface

// File: rtl/wb_burst_master.sv
// Wishbone initiator issuing single and incrementing-burst cycles from a command/data stream.
// Optional ack watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_burst_master #(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int bl      = 5,
  parameter int TIMEOUT = 255
) (
  input  logic               sys_clk,
  input  logic               RESETN,
  wb_burst_master_if.master  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, REQ} state_t;

  localparam logic [aw-1:0] ADDR_STEP = aw'(dw/8);
  localparam logic [2:0]    CTI_INCR  = 3'b010;
  localparam logic [2:0]    CTI_END   = 3'b111;

  state_t          r_state;
  logic            r_cmd_ready;
  logic            r_wdat_ready;
  logic            r_rdat_valid;
  logic [dw-1:0]   r_rdat;
  logic            r_rdat_last;
  logic            r_done;
  logic            r_err;
  logic            r_busy;
  logic            r_cyc;
  logic            r_stb;
  logic            r_we;
  logic [aw-1:0]   r_addr;
  logic [dw-1:0]   r_dat;
  logic [dw/8-1:0] r_sel;
  logic [2:0]      r_cti;
  logic [bl-1:0]   r_cnt;
  logic            w_last;
  logic            w_tmo_hit;

  assign w_last = (r_cnt == '0);

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tmo;

  // Counts consecutive REQ cycles without ack; any other state or an ack restarts it.
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      r_tmo <= '0;
    end else if (r_state != REQ || bus.wb_ack_i) begin
      r_tmo <= '0;
    end else begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_tmo_hit = (r_state == REQ) && !bus.wb_ack_i && (r_tmo == TW'(TIMEOUT - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT;
  assign w_tmo_hit    = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      r_state      <= IDLE;
      r_cmd_ready  <= 1'b0;
      r_wdat_ready <= 1'b0;
      r_rdat_valid <= 1'b0;
      r_rdat       <= '0;
      r_rdat_last  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_dat        <= '0;
      r_sel        <= '0;
      r_cti        <= '0;
      r_cnt        <= '0;
    end else begin
      r_rdat_valid <= 1'b0;
      r_rdat_last  <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (r_cmd_ready && bus.cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_cyc       <= 1'b1;
            r_we        <= bus.cmd_we;
            r_addr      <= bus.cmd_addr;
            r_sel       <= bus.cmd_sel;
            r_cnt       <= bus.cmd_len;
            r_cti       <= (bus.cmd_len == '0) ? CTI_END : CTI_INCR;
            if (bus.cmd_we) begin
              r_wdat_ready <= 1'b1;
              r_state      <= LOAD;
            end else begin
              r_stb   <= 1'b1;
              r_state <= REQ;
            end
          end
        end
        LOAD: begin
          if (bus.wdat_valid) begin
            r_dat        <= bus.wdat;
            r_wdat_ready <= 1'b0;
            r_stb        <= 1'b1;
            r_state      <= REQ;
          end
        end
        REQ: begin
          if (w_tmo_hit) begin
            // Abandon the remaining beats; the slave never answered.
            r_err       <= 1'b1;
            r_done      <= 1'b1;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_cti       <= '0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end else if (bus.wb_ack_i) begin
            r_addr <= r_addr + ADDR_STEP;
            r_cnt  <= r_cnt - bl'(1);
            if (!r_we) begin
              r_rdat_valid <= 1'b1;
              r_rdat       <= bus.wb_dat_i;
              r_rdat_last  <= w_last;
            end
            if (w_last) begin
              r_done      <= 1'b1;
              r_cyc       <= 1'b0;
              r_stb       <= 1'b0;
              r_we        <= 1'b0;
              r_cti       <= '0;
              r_busy      <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_state     <= IDLE;
            end else begin
              // Counter still holds the pre-decrement value, so 1 means the next beat is the last.
              r_cti <= (r_cnt == bl'(1)) ? CTI_END : CTI_INCR;
              if (r_we) begin
                r_stb        <= 1'b0;
                r_wdat_ready <= 1'b1;
                r_state      <= LOAD;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.wdat_ready = r_wdat_ready;
  assign bus.rdat_valid = r_rdat_valid;
  assign bus.rdat       = r_rdat;
  assign bus.rdat_last  = r_rdat_last;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.busy       = r_busy;
  assign bus.wb_cyc_o   = r_cyc;
  assign bus.wb_stb_o   = r_stb;
  assign bus.wb_we_o    = r_we;
  assign bus.wb_addr_o  = r_addr;
  assign bus.wb_dat_o   = r_dat;
  assign bus.wb_sel_o   = r_sel;
  assign bus.wb_cti_o   = r_cti;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master with a small memory-backed Wishbone slave model.
module tb_wb_burst_master;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wb_burst_master_if #(.dw(32), .aw(32), .bl(5)) bus ();

  wb_burst_master #(.dw(32), .aw(32), .bl(5), .TIMEOUT(255)) dut (
    .sys_clk (clk),
    .RESETN  (rstn),
    .bus     (bus)
  );

  // Slave model: ack after ack_dly stalled cycles, unwritten words read back as C0DE_<addr[15:0]>.
  bit [31:0] mem    [256];
  bit        mem_ok [256];
  int        ack_dly   = 0;
  bit        ack_en    = 1'b1;
  bit        force_ack = 1'b0;
  int        wcnt      = 0;
  logic [7:0] s_idx;

  assign s_idx        = bus.wb_addr_o[9:2];
  assign bus.wb_ack_i = force_ack | (bus.wb_cyc_o & bus.wb_stb_o & ack_en & (wcnt >= ack_dly));
  assign bus.wb_dat_i = mem_ok[s_idx] ? mem[s_idx] : {16'hC0DE, bus.wb_addr_o[15:0]};

  always @(posedge clk) begin
    if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i) wcnt <= wcnt + 1;
    else                                               wcnt <= 0;
    if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i && bus.wb_we_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.wb_sel_o[b]) mem[s_idx][8*b +: 8] <= bus.wb_dat_o[8*b +: 8];
      mem_ok[s_idx] <= 1'b1;
    end
  end

  // Bus monitor
  logic [31:0] q_addr[$];
  logic [31:0] q_dat[$];
  logic [2:0]  q_cti[$];
  logic [31:0] q_rd[$];
  logic        q_last[$];
  int          cyc_gap = 0;
  int          n_done  = 0;

  always @(negedge clk) begin
    if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i) begin
      q_addr.push_back(bus.wb_addr_o);
      q_cti.push_back(bus.wb_cti_o);
      q_dat.push_back(bus.wb_we_o ? bus.wb_dat_o : bus.wb_dat_i);
    end
    if (bus.rdat_valid) begin
      q_rd.push_back(bus.rdat);
      q_last.push_back(bus.rdat_last);
    end
    if (bus.busy && !bus.wb_cyc_o) cyc_gap++;
    if (bus.done) n_done++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_addr.delete(); q_dat.delete(); q_cti.delete(); q_rd.delete(); q_last.delete();
    cyc_gap = 0;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] a, input logic [4:0] len,
                          input logic [3:0] sel);
    int t = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_we = we; bus.cmd_addr = a; bus.cmd_len = len; bus.cmd_sel = sel;
    while (!bus.cmd_ready && t < 100) begin @(negedge clk); t++; end
    chk("cmd_accept", 64'(t < 100), 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we = ~we; bus.cmd_addr = ~a; bus.cmd_len = ~len; bus.cmd_sel = ~sel;
  endtask

  task automatic push_wdat(input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    bus.wdat_valid = 1'b1; bus.wdat = d;
    while (!bus.wdat_ready && t < 100) begin @(negedge clk); t++; end
    chk("wdat_accept", 64'(t < 100), 64'd1);
    @(posedge clk); #1;
    bus.wdat_valid = 1'b0; bus.wdat = 32'hxxxx_xxxx;
  endtask

  // st = {rdat_valid, rdat_last, err, cmd_ready, busy, wb_cyc_o} in the done cycle
  task automatic wait_done(output logic [5:0] st, output int cyc);
    int t = 0;
    @(negedge clk);
    while (!bus.done && t < 2000) begin @(negedge clk); t++; end
    chk("done_seen", 64'(t < 2000), 64'd1);
    st  = {bus.rdat_valid, bus.rdat_last, bus.err, bus.cmd_ready, bus.busy, bus.wb_cyc_o};
    cyc = t;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] st;
    int cyc;
    int nd0;
    int nstb;
    int t;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_sel = '0;
    bus.wdat_valid = 1'b0; bus.wdat = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {bus.cmd_ready, bus.wdat_ready, bus.rdat_valid, bus.rdat_last, bus.done, bus.err,
                     bus.busy, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_cti_o}, 64'd0);
    chk("rst_addr", bus.wb_addr_o, 64'd0);
    chk("rst_data", {bus.rdat, bus.wb_dat_o}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", bus.cmd_ready, 64'd1);

    // Single read, ack two cycles after stb
    ack_dly = 2; clear_q();
    send_cmd(1'b0, 32'h100, 5'd0, 4'hF);
    @(negedge clk);
    chk("rd1_start", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_cti_o, bus.busy, bus.cmd_ready},
        64'b1101_1110);
    wait_done(st, cyc);
    chk("rd1_done_st", st, 64'b110100);
    chk("rd1_latency", cyc, 64'd2);
    chk("rd1_nbeats", q_addr.size(), 64'd1);
    chk("rd1_addr", q_addr[0], 64'h100);
    chk("rd1_cti", q_cti[0], 64'b111);
    chk("rd1_rdat", q_rd[0], 64'hC0DE_0100);
    chk("rd1_last", q_last[0], 64'd1);

    // Ack while idle is ignored
    clear_q(); nd0 = n_done;
    @(negedge clk); force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    chk("ack_idle_bus", {bus.rdat_valid, bus.done, bus.busy, bus.wb_cyc_o, bus.cmd_ready}, 64'b00001);
    chk("ack_idle_addr", bus.wb_addr_o, 64'h104);
    chk("ack_idle_rd", q_rd.size(), 64'd0);
    chk("ack_idle_done", n_done - nd0, 64'd0);

    // Write burst 0x200, 8 beats
    ack_dly = 0; clear_q();
    send_cmd(1'b1, 32'h200, 5'd7, 4'hF);
    @(negedge clk);
    chk("wr_start", {bus.wb_cyc_o, bus.wb_stb_o, bus.wdat_ready, bus.busy}, 64'b1011);
    for (int i = 0; i < 8; i++) push_wdat(32'hA0 + i);
    wait_done(st, cyc);
    chk("wr8_done_st", st, 64'b000100);
    chk("wr8_nbeats", q_addr.size(), 64'd8);
    chk("wr8_cyc_gap", cyc_gap, 64'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wr8_addr%0d", i), q_addr[i], 64'(32'h200 + 4*i));
      chk($sformatf("wr8_cti%0d", i), q_cti[i], (i < 7) ? 64'b010 : 64'b111);
      chk($sformatf("wr8_dat%0d", i), q_dat[i], 64'(32'hA0 + i));
    end

    // Fill 0x220..0x27C, then read 32 beats back from 0x200
    clear_q();
    send_cmd(1'b1, 32'h220, 5'd23, 4'hF);
    for (int i = 0; i < 24; i++) push_wdat(32'hB0 + i);
    wait_done(st, cyc);
    chk("wr24_nbeats", q_addr.size(), 64'd24);
    clear_q();
    send_cmd(1'b0, 32'h200, 5'd31, 4'hF);
    wait_done(st, cyc);
    chk("rd32_done_st", st, 64'b110100);
    chk("rd32_cycles", cyc, 64'd32);
    chk("rd32_nrd", q_rd.size(), 64'd32);
    chk("rd32_last_addr", q_addr[31], 64'h27C);
    chk("rd32_cyc_gap", cyc_gap, 64'd0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("rd32_dat%0d", i), q_rd[i], (i < 8) ? 64'(32'hA0 + i) : 64'(32'hB0 + i - 8));
      chk($sformatf("rd32_last%0d", i), q_last[i], 64'(i == 31));
    end

    // Write with data withheld 5 cycles mid-burst, stray ack and command during the gap
    clear_q();
    send_cmd(1'b1, 32'h300, 5'd3, 4'hF);
    push_wdat(32'hD0);
    push_wdat(32'hD1);
    @(negedge clk);
    @(negedge clk); force_ack = 1'b1;
    @(negedge clk); force_ack = 1'b0;
    chk("gap_bus", {bus.wb_cyc_o, bus.wb_stb_o, bus.wdat_ready, bus.cmd_ready, bus.busy}, 64'b10101);
    bus.cmd_valid = 1'b1; bus.cmd_we = 1'b0; bus.cmd_addr = 32'h500; bus.cmd_len = 5'd2;
    @(negedge clk);
    @(negedge clk); bus.cmd_valid = 1'b0;
    push_wdat(32'hD2);
    push_wdat(32'hD3);
    wait_done(st, cyc);
    chk("gap_done_st", st, 64'b000100);
    chk("gap_nbeats", q_addr.size(), 64'd4);
    chk("gap_cyc_gap", cyc_gap, 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("gap_addr%0d", i), q_addr[i], 64'(32'h300 + 4*i));
      chk($sformatf("gap_dat%0d", i), q_dat[i], 64'(32'hD0 + i));
    end

    // Address wrap
    clear_q();
    send_cmd(1'b0, 32'hFFFF_FFFC, 5'd1, 4'hF);
    wait_done(st, cyc);
    chk("wrap_done_st", st, 64'b110100);
    chk("wrap_addr0", q_addr[0], 64'hFFFF_FFFC);
    chk("wrap_addr1", q_addr[1], 64'h0);
    chk("wrap_cti0", q_cti[0], 64'b010);
    chk("wrap_cti1", q_cti[1], 64'b111);
    chk("wrap_rd0", q_rd[0], 64'hC0DE_FFFC);
    chk("wrap_rd1", q_rd[1], 64'hC0DE_0000);

    // Slave that never acks
`ifdef WB_MASTER_TIMEOUT_EN
    ack_en = 1'b0; clear_q();
    send_cmd(1'b0, 32'h400, 5'd3, 4'hF);
    nstb = 0; t = 0;
    do begin
      @(negedge clk);
      if (bus.wb_stb_o) nstb++;
      t++;
    end while (!bus.done && t < 600);
    chk("tmo_bus", {bus.err, bus.done, bus.wb_cyc_o, bus.wb_stb_o, bus.rdat_valid, bus.rdat_last,
                    bus.cmd_ready}, 64'b1100001);
    chk("tmo_stb_cycles", nstb, 64'd255);
    @(posedge clk); #1;
    chk("tmo_nrd", q_rd.size(), 64'd0);
    ack_en = 1'b1; clear_q();
    send_cmd(1'b0, 32'h400, 5'd0, 4'hF);
    wait_done(st, cyc);
    chk("tmo_next_st", st, 64'b110100);
    chk("tmo_next_rd", q_rd[0], 64'hC0DE_0400);
`else
    ack_en = 1'b0; clear_q(); nstb = 0; t = 0;
    send_cmd(1'b0, 32'h400, 5'd0, 4'hF);
    repeat (300) @(negedge clk);
    chk("noack_wait", {bus.wb_cyc_o, bus.wb_stb_o, bus.err, bus.done, bus.busy}, 64'b11001);
    ack_en = 1'b1;
    wait_done(st, cyc);
    chk("noack_done_st", st, 64'b110100);
    chk("noack_rd", q_rd[0], 64'hC0DE_0400);
`endif

    // Asynchronous reset in the middle of a read burst
    ack_dly = 3; clear_q();
    send_cmd(1'b0, 32'h200, 5'd7, 4'hF);
    repeat (6) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rstmid_ctrl", {bus.wb_cyc_o, bus.wb_stb_o, bus.busy, bus.done, bus.rdat_valid, bus.cmd_ready,
                        bus.err, bus.wdat_ready, bus.wb_cti_o}, 64'd0);
    chk("rstmid_addr", bus.wb_addr_o, 64'd0);
    @(negedge clk); rstn = 1'b1; nd0 = n_done;
    repeat (3) @(negedge clk);
    chk("rstmid_idle", {bus.cmd_ready, bus.busy, bus.wb_cyc_o, bus.done}, 64'b1000);
    chk("rstmid_nodone", n_done - nd0, 64'd0);

    // Normal operation after the reset
    ack_dly = 0; clear_q();
    send_cmd(1'b0, 32'h200, 5'd0, 4'hF);
    wait_done(st, cyc);
    chk("post_rst_st", st, 64'b110100);
    chk("post_rst_rd", q_rd[0], 64'hA0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
